// File: rtl/pipe_exe_mc_if.sv
// Handshake and payload bundle between ID/EX, the execute stage and MEM.
interface pipe_exe_mc_if #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned CTRL_W  = 9
);
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         op_kind;
    logic [3:0]         aluc;
    logic               alu_mux1_sel;
    logic               alu_mux2_sel;
    logic [WIDTH-1:0]   pc4;
    logic [WIDTH-1:0]   rs_data;
    logic [WIDTH-1:0]   rt_data;
    logic [WIDTH-1:0]   imm;
    logic [WIDTH-1:0]   shamt;
    logic [RADDR_W-1:0] rf_waddr;
    logic [CTRL_W-1:0]  ctrl_in;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   exe_lo;
    logic [WIDTH-1:0]   exe_hi;
    logic [WIDTH-1:0]   exe_pc4;
    logic [WIDTH-1:0]   exe_rt_data;
    logic [RADDR_W-1:0] exe_rf_waddr;
    logic [CTRL_W-1:0]  exe_ctrl;
    logic               busy;

    // Upstream/downstream environment view
    modport master (
        output flush, in_valid, op_kind, aluc, alu_mux1_sel, alu_mux2_sel,
               pc4, rs_data, rt_data, imm, shamt, rf_waddr, ctrl_in, out_ready,
        input  in_ready, out_valid, exe_lo, exe_hi, exe_pc4, exe_rt_data,
               exe_rf_waddr, exe_ctrl, busy
    );

    // Execute stage view
    modport slave (
        input  flush, in_valid, op_kind, aluc, alu_mux1_sel, alu_mux2_sel,
               pc4, rs_data, rt_data, imm, shamt, rf_waddr, ctrl_in, out_ready,
        output in_ready, out_valid, exe_lo, exe_hi, exe_pc4, exe_rt_data,
               exe_rf_waddr, exe_ctrl, busy
    );
endinterface

// File: rtl/pipe_exe_mc.sv
// Execute stage: 1-cycle ALU plus iterative unsigned multiply (and divide when
// EXE_DIV_EN is defined). Registered result with valid/ready on both sides.
module pipe_exe_mc #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned CTRL_W  = 9
) (
    input logic          clk,
    input logic          rst,
    pipe_exe_mc_if.slave bus
);
    localparam int unsigned SH_W  = $clog2(WIDTH);
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef EXE_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
    logic [WIDTH-1:0]   sb_pc4_q, sb_pc4_d, sb_rt_q, sb_rt_d;
    logic [RADDR_W-1:0] sb_waddr_q, sb_waddr_d;
    logic [CTRL_W-1:0]  sb_ctrl_q, sb_ctrl_d;
    logic               out_valid_q, out_valid_d, busy_q, busy_d;
    logic [WIDTH-1:0]   out_lo_q, out_lo_d, out_hi_q, out_hi_d;
    logic [WIDTH-1:0]   out_pc4_q, out_pc4_d, out_rt_q, out_rt_d;
    logic [RADDR_W-1:0] out_waddr_q, out_waddr_d;
    logic [CTRL_W-1:0]  out_ctrl_q, out_ctrl_d;

    logic               out_free_c, accept_c, is_mul_c, is_div_c;
    logic [WIDTH-1:0]   a_c, b_c, alu_c;
    logic [SH_W-1:0]    sh_c;
    logic [WIDTH:0]     mul_sum_c;
`ifdef EXE_DIV_EN
    logic [WIDTH:0]     div_shift_c;
    logic [WIDTH-1:0]   div_rem_c;
    logic               div_ge_c;
`endif

    assign out_free_c   = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = (state_q == S_IDLE) & out_free_c;
    assign accept_c     = bus.in_valid & bus.in_ready & ~bus.flush;
    assign is_mul_c     = (bus.op_kind == 2'd1);
    assign is_div_c     = (bus.op_kind == 2'd2);
    assign a_c          = bus.alu_mux1_sel ? bus.rs_data : bus.shamt;
    assign b_c          = bus.alu_mux2_sel ? bus.imm : bus.rt_data;
    assign sh_c         = a_c[SH_W-1:0];

    // Shift-add step: add multiplicand when the multiplier LSB is set, then shift right
    assign mul_sum_c = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});

`ifdef EXE_DIV_EN
    // Restoring step: shift next dividend bit into the remainder and trial-subtract
    assign div_shift_c = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_ge_c    = (div_shift_c >= {1'b0, opnd_q});
    assign div_rem_c   = div_shift_c[WIDTH-1:0] - opnd_q;
`endif

    assign bus.out_valid    = out_valid_q;
    assign bus.busy         = busy_q;
    assign bus.exe_lo       = out_lo_q;
    assign bus.exe_hi       = out_hi_q;
    assign bus.exe_pc4      = out_pc4_q;
    assign bus.exe_rt_data  = out_rt_q;
    assign bus.exe_rf_waddr = out_waddr_q;
    assign bus.exe_ctrl     = out_ctrl_q;

    // Single-cycle ALU
    always_comb begin
        alu_c = '0;
        case (bus.aluc)
            4'd0:    alu_c = a_c + b_c;
            4'd1:    alu_c = a_c - b_c;
            4'd2:    alu_c = a_c & b_c;
            4'd3:    alu_c = a_c | b_c;
            4'd4:    alu_c = a_c ^ b_c;
            4'd5:    alu_c = ~(a_c | b_c);
            4'd6:    alu_c = WIDTH'($signed(a_c) < $signed(b_c));
            4'd7:    alu_c = WIDTH'(a_c < b_c);
            4'd8:    alu_c = b_c << sh_c;
            4'd9:    alu_c = b_c >> sh_c;
            4'd10:   alu_c = $unsigned($signed(b_c) >>> sh_c);
            4'd11:   alu_c = b_c << 16;
            default: alu_c = '0;
        endcase
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_c && is_mul_c) state_d = S_MUL;
`ifdef EXE_DIV_EN
                    if (accept_c && is_div_c) state_d = S_DIV;
`endif
                end
                S_MUL:   if (cnt_q == CNT_LAST) state_d = S_DONE;
`ifdef EXE_DIV_EN
                S_DIV:   if (cnt_q == CNT_LAST) state_d = S_DONE;
`endif
                S_DONE:  if (out_free_c) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM outputs and datapath next values
    always_comb begin
        cnt_d       = cnt_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        opnd_d      = opnd_q;
        sb_pc4_d    = sb_pc4_q;
        sb_rt_d     = sb_rt_q;
        sb_waddr_d  = sb_waddr_q;
        sb_ctrl_d   = sb_ctrl_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q & ~bus.out_ready;
        out_lo_d    = out_lo_q;
        out_hi_d    = out_hi_q;
        out_pc4_d   = out_pc4_q;
        out_rt_d    = out_rt_q;
        out_waddr_d = out_waddr_q;
        out_ctrl_d  = out_ctrl_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
            cnt_d       = '0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_c) begin
                        cnt_d      = '0;
                        sb_pc4_d   = bus.pc4;
                        sb_rt_d    = bus.rt_data;
                        sb_waddr_d = bus.rf_waddr;
                        sb_ctrl_d  = bus.ctrl_in;
                        if (is_mul_c) begin
                            acc_hi_d = '0;
                            acc_lo_d = b_c;
                            opnd_d   = a_c;
                            busy_d   = 1'b1;
`ifdef EXE_DIV_EN
                        end else if (is_div_c) begin
                            acc_hi_d = '0;
                            acc_lo_d = a_c;
                            opnd_d   = b_c;
                            busy_d   = 1'b1;
`endif
                        end else begin
                            out_valid_d = 1'b1;
                            out_lo_d    = is_div_c ? '0 : alu_c;
                            out_hi_d    = '0;
                            out_pc4_d   = bus.pc4;
                            out_rt_d    = bus.rt_data;
                            out_waddr_d = bus.rf_waddr;
                            out_ctrl_d  = bus.ctrl_in;
                        end
                    end
                end
                S_MUL: begin
                    acc_hi_d = mul_sum_c[WIDTH:1];
                    acc_lo_d = {mul_sum_c[0], acc_lo_q[WIDTH-1:1]};
                    cnt_d    = CNT_W'(cnt_q + 1'b1);
                    if (cnt_q == CNT_LAST) begin
                        cnt_d  = '0;
                        busy_d = 1'b0;
                    end
                end
`ifdef EXE_DIV_EN
                S_DIV: begin
                    acc_hi_d = div_ge_c ? div_rem_c : div_shift_c[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge_c};
                    cnt_d    = CNT_W'(cnt_q + 1'b1);
                    if (cnt_q == CNT_LAST) begin
                        cnt_d  = '0;
                        busy_d = 1'b0;
                    end
                end
`endif
                S_DONE: begin
                    if (out_free_c) begin
                        out_valid_d = 1'b1;
                        out_lo_d    = acc_lo_q;
                        out_hi_d    = acc_hi_q;
                        out_pc4_d   = sb_pc4_q;
                        out_rt_d    = sb_rt_q;
                        out_waddr_d = sb_waddr_q;
                        out_ctrl_d  = sb_ctrl_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Datapath, sideband and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            opnd_q      <= '0;
            sb_pc4_q    <= '0;
            sb_rt_q     <= '0;
            sb_waddr_q  <= '0;
            sb_ctrl_q   <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_lo_q    <= '0;
            out_hi_q    <= '0;
            out_pc4_q   <= '0;
            out_rt_q    <= '0;
            out_waddr_q <= '0;
            out_ctrl_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            opnd_q      <= opnd_d;
            sb_pc4_q    <= sb_pc4_d;
            sb_rt_q     <= sb_rt_d;
            sb_waddr_q  <= sb_waddr_d;
            sb_ctrl_q   <= sb_ctrl_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_lo_q    <= out_lo_d;
            out_hi_q    <= out_hi_d;
            out_pc4_q   <= out_pc4_d;
            out_rt_q    <= out_rt_d;
            out_waddr_q <= out_waddr_d;
            out_ctrl_q  <= out_ctrl_d;
        end
    end
endmodule

// File: tb/tb_pipe_exe_mc.sv
// Scoreboard bench for pipe_exe_mc: directed ops push expected results, a
// monitor pops and compares each result the stage hands downstream.
module tb_pipe_exe_mc;
    localparam int unsigned W  = 32;
    localparam int unsigned RW = 5;
    localparam int unsigned CW = 9;

    typedef struct {
        logic [W-1:0]  lo;
        logic [W-1:0]  hi;
        logic [W-1:0]  pc4;
        logic [W-1:0]  rt;
        logic [RW-1:0] waddr;
        logic [CW-1:0] ctrl;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb_q[$];
    int   n_err = 0;
    int   n_chk = 0;
    int   tag   = 0;

    pipe_exe_mc_if #(.WIDTH(W), .RADDR_W(RW), .CTRL_W(CW)) bus ();

    pipe_exe_mc #(.WIDTH(W), .RADDR_W(RW), .CTRL_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Present one op and hold it until accepted; returns cycles spent waiting
    task automatic send(input logic [1:0] kind, input logic [3:0] code,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic use_imm,
                        input logic push, input logic [W-1:0] elo, input logic [W-1:0] ehi,
                        output int waits);
        exp_t e;
        tag++;
        bus.op_kind = kind;
        bus.aluc    = code;
        if (use_imm) begin
            bus.alu_mux1_sel = 1'b0;
            bus.alu_mux2_sel = 1'b1;
            bus.shamt        = a;
            bus.imm          = b;
            bus.rs_data      = 32'hBAD0_0000 | W'(tag);
            bus.rt_data      = 32'hDEAD_0000 | W'(tag);
        end else begin
            bus.alu_mux1_sel = 1'b1;
            bus.alu_mux2_sel = 1'b0;
            bus.rs_data      = a;
            bus.rt_data      = b;
            bus.shamt        = 32'h0000_001F;
            bus.imm          = 32'h5A5A_5A5A;
        end
        bus.pc4      = 32'h0040_0000 + W'(tag * 4);
        bus.rf_waddr = RW'(tag);
        bus.ctrl_in  = CW'(tag * 37);
        e.lo    = elo;
        e.hi    = ehi;
        e.pc4   = bus.pc4;
        e.rt    = bus.rt_data;
        e.waddr = bus.rf_waddr;
        e.ctrl  = bus.ctrl_in;
        if (push) sb_q.push_back(e);
        bus.in_valid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!bus.in_ready) begin
            waits++;
            if (waits > 200) begin
                $display("FAIL send_timeout: in_ready=0 after 200 cycles, required 1");
                $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
                $fatal(1, "send timeout");
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Let outstanding results leave the stage
    task automatic drain();
        int k;
        k = 0;
        while ((sb_q.size() != 0 || bus.out_valid) && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_queue_empty", 64'(sb_q.size()), 64'd0);
    endtask

    // Monitor: compare every result taken downstream against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_result: got exe_lo=0x%0h, required no result", bus.exe_lo);
                end else begin
                    e = sb_q.pop_front();
                    chk("exe_lo", 64'(bus.exe_lo), 64'(e.lo));
                    chk("exe_hi", 64'(bus.exe_hi), 64'(e.hi));
                    chk("exe_pc4", 64'(bus.exe_pc4), 64'(e.pc4));
                    chk("exe_rt_data", 64'(bus.exe_rt_data), 64'(e.rt));
                    chk("exe_rf_waddr", 64'(bus.exe_rf_waddr), 64'(e.waddr));
                    chk("exe_ctrl", 64'(bus.exe_ctrl), 64'(e.ctrl));
                end
            end
        end
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        int w, k, busy_cnt, stall_cnt, ov_cnt;
        clk = 1'b0;
        rst = 1'b1;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.op_kind = 2'd0; bus.aluc = 4'd0; bus.alu_mux1_sel = 1'b0; bus.alu_mux2_sel = 1'b0;
        bus.pc4 = '0; bus.rs_data = '0; bus.rt_data = '0; bus.imm = '0; bus.shamt = '0;
        bus.rf_waddr = '0; bus.ctrl_in = '0;

        // Reset values
        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_exe_lo", 64'(bus.exe_lo), 64'd0);
        chk("rst_exe_hi", 64'(bus.exe_hi), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;

        // ADDU wrap, 1-cycle latency
        send(2'd0, 4'd0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1, 32'h0, 32'h0, w);
        chk("alu_latency_out_valid", 64'(bus.out_valid), 64'd1);

        // Back-to-back ALU table
        send(2'd0, 4'd1,  32'h5,         32'h7,         1'b0, 1'b1, 32'hFFFF_FFFE, 32'h0, w);
        chk("b2b_no_wait", 64'(w), 64'd0);
        send(2'd0, 4'd2,  32'hF0F0_FF00, 32'h0FF0_F0F0, 1'b0, 1'b1, 32'h00F0_F000, 32'h0, w);
        send(2'd0, 4'd3,  32'hF0F0_FF00, 32'h0FF0_F0F0, 1'b0, 1'b1, 32'hFFF0_FFF0, 32'h0, w);
        send(2'd0, 4'd4,  32'hF0F0_FF00, 32'h0FF0_F0F0, 1'b0, 1'b1, 32'hFF00_0FF0, 32'h0, w);
        send(2'd0, 4'd5,  32'hF0F0_FF00, 32'h0FF0_F0F0, 1'b0, 1'b1, 32'h000F_000F, 32'h0, w);
        send(2'd0, 4'd6,  32'hFFFF_FFFF, 32'h1,         1'b0, 1'b1, 32'h1,         32'h0, w);
        send(2'd0, 4'd7,  32'hFFFF_FFFF, 32'h1,         1'b0, 1'b1, 32'h0,         32'h0, w);
        send(2'd0, 4'd7,  32'h1,         32'hFFFF_FFFF, 1'b0, 1'b1, 32'h1,         32'h0, w);
        send(2'd0, 4'd8,  32'h24,        32'h8000_0001, 1'b0, 1'b1, 32'h0000_0010, 32'h0, w);
        send(2'd0, 4'd9,  32'h8,         32'h8000_0000, 1'b0, 1'b1, 32'h0080_0000, 32'h0, w);
        send(2'd0, 4'd10, 32'h4,         32'h8000_0000, 1'b0, 1'b1, 32'hF800_0000, 32'h0, w);
        send(2'd0, 4'd11, 32'h9,         32'h1234,      1'b1, 1'b1, 32'h1234_0000, 32'h0, w);
        send(2'd0, 4'd0,  32'h3,         32'h4,         1'b1, 1'b1, 32'h7,         32'h0, w);
        send(2'd0, 4'd12, 32'h5,         32'h6,         1'b0, 1'b1, 32'h0,         32'h0, w);
        send(2'd3, 4'd0,  32'h2,         32'h3,         1'b0, 1'b1, 32'h5,         32'h0, w);
        drain();

        // MULTU max operands: busy window and latency
        send(2'd1, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE, w);
        k = 0; busy_cnt = 0; stall_cnt = 0;
        while (!bus.out_valid && k < 100) begin
            @(negedge clk);
            busy_cnt += int'(bus.busy);
            if (bus.busy && !bus.in_ready) stall_cnt++;
            @(posedge clk);
            #1;
            k++;
        end
        chk("mul_latency_edges_after_accept", 64'(k), 64'd33);
        chk("mul_busy_cycles", 64'(busy_cnt), 64'd32);
        chk("mul_stall_cycles", 64'(stall_cnt), 64'd32);
        send(2'd1, 4'd0, 32'h1234_5678, 32'h10, 1'b0, 1'b1, 32'h2345_6780, 32'h1, w);
        drain();

        // DIVU
`ifdef EXE_DIV_EN
        send(2'd2, 4'd0, 32'd100,       32'd7,  1'b0, 1'b1, 32'd14,        32'd2,  w);
        send(2'd2, 4'd0, 32'd5,         32'd0,  1'b0, 1'b1, 32'hFFFF_FFFF, 32'd5,  w);
        send(2'd2, 4'd0, 32'hFFFF_FFFF, 32'h10, 1'b0, 1'b1, 32'h0FFF_FFFF, 32'hF, w);
`else
        send(2'd2, 4'd0, 32'd100, 32'd7, 1'b0, 1'b1, 32'd0, 32'd0, w);
        chk("nodiv_latency_out_valid", 64'(bus.out_valid), 64'd1);
        send(2'd2, 4'd0, 32'd5,   32'd0, 1'b0, 1'b1, 32'd0, 32'd0, w);
`endif
        drain();

        // Back-pressure: SLT held for 3 cycles, then next op enters on release
        bus.out_ready = 1'b0;
        send(2'd0, 4'd6, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 32'h1, 32'h0, w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_exe_lo", 64'(bus.exe_lo), 64'd1);
            chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(2'd0, 4'd0, 32'd7, 32'd8, 1'b0, 1'b1, 32'd15, 32'h0, w);
        chk("release_same_cycle_accept", 64'(w), 64'd0);
        drain();

        // Flush at iteration 10 of MULTU: no result ever issues
        send(2'd1, 4'd0, 32'd3, 32'd5, 1'b0, 1'b0, 32'd0, 32'd0, w);
        repeat (9) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("flush_busy", 64'(bus.busy), 64'd0);
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        ov_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            ov_cnt += int'(bus.out_valid);
        end
        chk("flush_no_result_cycles", 64'(ov_cnt), 64'd0);

        // Op presented together with flush is not accepted
        bus.op_kind = 2'd0; bus.aluc = 4'd0; bus.alu_mux1_sel = 1'b1; bus.alu_mux2_sel = 1'b0;
        bus.rs_data = 32'd1; bus.rt_data = 32'd1;
        bus.in_valid = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        chk("flush_blocks_accept", 64'(bus.out_valid), 64'd0);

        // Flush drops a held result
        bus.out_ready = 1'b0;
        send(2'd0, 4'd0, 32'd1, 32'd1, 1'b0, 1'b0, 32'd0, 32'd0, w);
        chk("held_before_flush", 64'(bus.out_valid), 64'd1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        chk("flush_drops_held", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;

        // Async reset mid-iteration, then a fresh SRA
`ifdef EXE_DIV_EN
        send(2'd2, 4'd0, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0, 32'd0, w);
`else
        send(2'd1, 4'd0, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0, 32'd0, w);
`endif
        repeat (5) @(posedge clk);
        #3;
        chk("pre_reset_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_exe_lo", 64'(bus.exe_lo), 64'd0);
        chk("midrst_exe_pc4", 64'(bus.exe_pc4), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(2'd0, 4'd10, 32'h4, 32'h8000_0000, 1'b0, 1'b1, 32'hF800_0000, 32'h0, w);
        drain();
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
